score_pulse_gen: RTL

//  Upstream feeder of the score display stage: turns game hit events into single-cycle point pulses (P).

---
 rtl/score_pulse_gen_if.sv | 36 +++
 rtl/score_pulse_gen.sv | 114 +++++++++++
 2 files changed

// File: rtl/score_pulse_gen_if.sv
// Hit-event and point-pulse bundle between collision logic and the pulse generator.
// SCORE_DOUBLE_EN adds the DBL strobe qualifier.
interface score_pulse_gen_if #(
  parameter int PEND_W = 6
);
  logic              CLR;
  logic              HIT;
  logic [1:0]        HIT_TYPE;
`ifdef SCORE_DOUBLE_EN
  logic              DBL;
`endif
  logic              P;
  logic              BUSY;
  logic [PEND_W-1:0] PENDING;
  logic              OVF;

`ifdef SCORE_DOUBLE_EN
  modport master (
    output CLR, HIT, HIT_TYPE, DBL,
    input  P, BUSY, PENDING, OVF
  );
  modport slave (
    input  CLR, HIT, HIT_TYPE, DBL,
    output P, BUSY, PENDING, OVF
  );
`else
  modport master (
    output CLR, HIT, HIT_TYPE,
    input  P, BUSY, PENDING, OVF
  );
  modport slave (
    input  CLR, HIT, HIT_TYPE,
    output P, BUSY, PENDING, OVF
  );
`endif
endinterface

// File: rtl/score_pulse_gen.sv
// Converts hit events into a paced stream of single-cycle point pulses.
// Define SCORE_DOUBLE_EN to enable the DBL (double points) input.
module score_pulse_gen #(
  parameter int         PEND_W    = 6,
  parameter int         PULSE_GAP = 3,
  parameter logic [3:0] PTS0      = 4'd1,
  parameter logic [3:0] PTS1      = 4'd2,
  parameter logic [3:0] PTS2      = 4'd3,
  parameter logic [3:0] PTS3      = 4'd5
) (
  input logic              CLK,
  input logic              RST,
  score_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int GW = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam int SW = PEND_W + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(PULSE_GAP - 1);
  localparam logic [SW-1:0] MAXV = SW'((1 << PEND_W) - 1);

  state_e            state_q, state_d;
  logic [GW-1:0]     cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic [3:0]        pts;
  logic [4:0]        credit;
  logic [SW-1:0]     dec;
  logic [SW-1:0]     sum;

  always_comb begin
    pts = PTS0;
    unique case (bus.HIT_TYPE)
      2'd0: pts = PTS0;
      2'd1: pts = PTS1;
      2'd2: pts = PTS2;
      2'd3: pts = PTS3;
      default: pts = PTS0;
    endcase
  end

  always_comb begin
    credit = {1'b0, pts};
`ifdef SCORE_DOUBLE_EN
    if (bus.DBL) credit = {pts, 1'b0};
`endif
    if (!bus.HIT) credit = 5'd0;
  end

  // Credit and drain land on the same edge, so no point is lost.
  assign dec = (state_q == PULSE) ? SW'(1) : SW'(0);
  assign sum = {1'b0, pend_q} + SW'(credit) - dec;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = sum[PEND_W-1:0];
    ovf_d   = ovf_q;
    if (sum > MAXV) begin
      pend_d = MAXV[PEND_W-1:0];
      ovf_d  = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) state_d = PULSE;
      end
      PULSE: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.CLR) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.P       = (state_q == PULSE);
  assign bus.BUSY    = (pend_q != '0) || (state_q != IDLE);
  assign bus.PENDING = pend_q;
  assign bus.OVF     = ovf_q;

endmodule
